writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Write-back end of the 16-bit RISC pipeline. Drives the register-file write port (RegWrite / write_register / write_Data) that the decode stage consumes.
- Holds the MEM/WB pipeline register and the result-select mux (ALU result vs. load data).
- Keeps a per-register pending-write scoreboard. Decode uses it for RAW-hazard stall and same-cycle write-port bypass.

Parameters:
- DATA_W, 16, datapath width
- NREG, 8, architectural registers (address width 3)
- CNT_W, 2, scoreboard counter width per register (max 3 in flight)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM stage holds a valid instruction this cycle
- mem_RegWrite  in  1  instruction writes a register
- mem_MemtoReg  in  1  1 = write load data, 0 = write ALU result
- mem_dest_reg  in  3  destination register
- mem_alu_result  in  16  ALU result from MEM stage
- mem_read_data  in  16  data-memory read data
- issue_valid  in  1  decode issues an instruction this cycle
- issue_RegWrite  in  1  issued instruction writes a register
- issue_dest_reg  in  3  destination of issued instruction
- rs1_addr  in  3  decode read address 1 (instruction bits 12:10)
- rs2_addr  in  3  decode read address 2 (instruction bits 9:7)
- rs1_use, rs2_use  in  1 each  operand actually consumed
- RegWrite  out  1  register-file write enable
- write_register  out  3  register-file write address
- write_Data  out  16  register-file write data
- hazard_stall  out  1  decode must hold; issue is not accepted
- bypass_1_en, bypass_2_en  out  1 each  substitute write_Data for read_data_1 / read_data_2
- sb_overflow, sb_underflow  out  1 each  sticky scoreboard error flags

Behaviour:
- Reset (async, rst_n=0): WB register invalid; RegWrite=0, write_register=0, write_Data=0; all counters 0; sticky flags 0. Combinational outputs then evaluate to 0.
- MEM/WB register: at each edge, wb_valid <= mem_valid. When mem_valid=1, capture RegWrite, dest and selected data (mem_MemtoReg ? mem_read_data : mem_alu_result).
  - Latency: exactly 1 cycle from MEM inputs to the write port.
  - RegWrite = wb_valid & captured RegWrite. When not writing, write_register and write_Data hold their last values.
- All NREG registers are writable, including register 0. There is no hardwired zero.
- Retire: at an edge where RegWrite=1, counter[write_register] decrements.
  - If that counter is 0: it stays 0 and sb_underflow sets.
- Issue accept: issue_fire = issue_valid & issue_RegWrite & ~hazard_stall.
  - At that edge, counter[issue_dest_reg] increments.
- Retire and issue to the same register in the same edge: counter unchanged.
- Operand hazard (per operand X):
  - pend_X = rsX_use & (counter[rsX_addr] != 0).
  - bypass_X_en = pend_X & counter[rsX_addr]==1 & RegWrite & write_register==rsX_addr. No stall in this case.
  - Otherwise pend_X raises the stall.
  - If rsX_use=0, bypass_X_en=0.
- Full condition: full = issue_valid & issue_RegWrite & counter[issue_dest_reg]==3, unless that register retires this cycle.
- hazard_stall = (pend_1 & ~bypass_1_en) | (pend_2 & ~bypass_2_en) | full. Purely combinational, same cycle.
- A counter already at 3 that is reached by a forced increment saturates at 3 and sets sb_overflow. This happens only if decode ignores stall; it cannot occur through issue_fire.
- Sticky flags clear only on reset.
- Reset mid-operation: in-flight write is dropped (RegWrite=0 immediately, asynchronously); scoreboard cleared.

Test Plan:
- Reset/latency: rst_n=0 for 2 cycles, then mem_valid=1, RegWrite=1, MemtoReg=0, dest=3, alu=0x1234 -> next cycle RegWrite=1, write_register=3, write_Data=0x1234; following cycle RegWrite=0 if mem_valid=0.
- Load select: MemtoReg=1, read_data=0xBEEF, alu=0x0001, dest=5 -> write_Data=0xBEEF at +1 cycle.
- RAW stall: issue dest=2 (counter 1), next cycle rs1_addr=2, rs1_use=1 with write port idle -> hazard_stall=1. Deliver dest=2 via MEM; when the write port shows reg 2 -> stall=0, bypass_1_en=1. Cycle after: counter 0, bypass 0.
- Counter depth: three issues to reg 4, fourth issue to reg 4 -> hazard_stall=1, counter stays 3, sb_overflow stays 0. Retire one in same cycle as issue -> no stall, counter stays 3.
- Simultaneous: issue dest=6 and retire reg 6 (counter 1) same edge -> counter remains 1. rs2_use on reg 6 with rs2_use=0 -> no stall.
- Underflow and async reset: retire reg 7 with counter 0 -> sb_underflow=1 sticky. Assert rst_n mid-cycle while RegWrite=1 -> RegWrite and flag clear without waiting for clk.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Write-back stage bus: MEM-stage results in, decode issue/operand queries in,
// register-file write port and hazard/bypass/status signals out.
// Ports: master = upstream pipeline/decode side, slave = writeback_stage.
interface writeback_stage_if #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
);
  localparam int AW = $clog2(NREG);

  // MEM stage result
  logic              mem_valid;
  logic              mem_RegWrite;
  logic              mem_MemtoReg;
  logic [AW-1:0]     mem_dest_reg;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_read_data;

  // decode issue and operand lookups
  logic              issue_valid;
  logic              issue_RegWrite;
  logic [AW-1:0]     issue_dest_reg;
  logic [AW-1:0]     rs1_addr;
  logic [AW-1:0]     rs2_addr;
  logic              rs1_use;
  logic              rs2_use;

  // register-file write port
  logic              RegWrite;
  logic [AW-1:0]     write_register;
  logic [DATA_W-1:0] write_Data;

  // hazard control and status
  logic              hazard_stall;
  logic              bypass_1_en;
  logic              bypass_2_en;
  logic              sb_overflow;
  logic              sb_underflow;

  modport master (
    output mem_valid, mem_RegWrite, mem_MemtoReg, mem_dest_reg,
           mem_alu_result, mem_read_data,
           issue_valid, issue_RegWrite, issue_dest_reg,
           rs1_addr, rs2_addr, rs1_use, rs2_use,
    input  RegWrite, write_register, write_Data,
           hazard_stall, bypass_1_en, bypass_2_en,
           sb_overflow, sb_underflow
  );

  modport slave (
    input  mem_valid, mem_RegWrite, mem_MemtoReg, mem_dest_reg,
           mem_alu_result, mem_read_data,
           issue_valid, issue_RegWrite, issue_dest_reg,
           rs1_addr, rs2_addr, rs1_use, rs2_use,
    output RegWrite, write_register, write_Data,
           hazard_stall, bypass_1_en, bypass_2_en,
           sb_overflow, sb_underflow
  );
endinterface

// File: rtl/writeback_stage.sv
// Write-back stage: MEM/WB register + result mux driving the register-file
// write port, plus a per-register pending-write scoreboard for decode.
// Latency: 1 cycle MEM -> write port. Backpressure: hazard_stall (combinational)
// refuses an issue on an unresolved RAW operand or a full destination counter.
// Ports: clk, rst_n (async active-low), bus (writeback_stage_if.slave).
module writeback_stage #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int CNT_W  = 2
) (
  input logic              clk,
  input logic              rst_n,
  writeback_stage_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // MEM/WB pipeline register
  logic              r_wb_valid;
  logic              r_wb_regwrite;
  logic [AW-1:0]     r_wb_dest;
  logic [DATA_W-1:0] r_wb_data;

  // scoreboard
  logic [CNT_W-1:0]  r_cnt [NREG];
  logic              r_overflow;
  logic              r_underflow;

  logic              w_retire;
  logic              w_issue_fire;
  logic              w_pend_1;
  logic              w_pend_2;
  logic              w_byp_1;
  logic              w_byp_2;
  logic              w_full;
  logic              w_stall;
  logic [CNT_W-1:0]  w_cnt_rs1;
  logic [CNT_W-1:0]  w_cnt_rs2;
  logic [CNT_W-1:0]  w_cnt_dst;
  logic [NREG-1:0]   w_inc;
  logic [NREG-1:0]   w_dec;

  // Dest/data only move on a real register write so that the write port
  // keeps showing the last written register while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid    <= 1'b0;
      r_wb_regwrite <= 1'b0;
      r_wb_dest     <= '0;
      r_wb_data     <= '0;
    end else begin
      r_wb_valid <= bus.mem_valid;
      if (bus.mem_valid) begin
        r_wb_regwrite <= bus.mem_RegWrite;
        if (bus.mem_RegWrite) begin
          r_wb_dest <= bus.mem_dest_reg;
          r_wb_data <= bus.mem_MemtoReg ? bus.mem_read_data : bus.mem_alu_result;
        end
      end
    end
  end

  assign w_retire           = r_wb_valid & r_wb_regwrite;
  assign bus.RegWrite       = w_retire;
  assign bus.write_register = r_wb_dest;
  assign bus.write_Data     = r_wb_data;

  assign w_cnt_rs1 = r_cnt[bus.rs1_addr];
  assign w_cnt_rs2 = r_cnt[bus.rs2_addr];
  assign w_cnt_dst = r_cnt[bus.issue_dest_reg];

  // An operand whose only outstanding write is on the port right now can be
  // forwarded instead of stalling.
  assign w_pend_1 = bus.rs1_use & (w_cnt_rs1 != CNT_ZERO);
  assign w_pend_2 = bus.rs2_use & (w_cnt_rs2 != CNT_ZERO);
  assign w_byp_1  = w_pend_1 & (w_cnt_rs1 == CNT_ONE) & w_retire &
                    (r_wb_dest == bus.rs1_addr);
  assign w_byp_2  = w_pend_2 & (w_cnt_rs2 == CNT_ONE) & w_retire &
                    (r_wb_dest == bus.rs2_addr);

  // A saturated counter may still accept an issue when it retires this edge.
  assign w_full = bus.issue_valid & bus.issue_RegWrite & (w_cnt_dst == CNT_MAX) &
                  ~(w_retire & (r_wb_dest == bus.issue_dest_reg));

  assign w_stall      = (w_pend_1 & ~w_byp_1) | (w_pend_2 & ~w_byp_2) | w_full;
  assign w_issue_fire = bus.issue_valid & bus.issue_RegWrite & ~w_stall;

  assign bus.hazard_stall = w_stall;
  assign bus.bypass_1_en  = w_byp_1;
  assign bus.bypass_2_en  = w_byp_2;
  assign bus.sb_overflow  = r_overflow;
  assign bus.sb_underflow = r_underflow;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < NREG; i++) begin
      w_inc[i] = w_issue_fire & (bus.issue_dest_reg == AW'(i));
      w_dec[i] = w_retire & (r_wb_dest == AW'(i));
    end
  end

  // Increment and decrement of the same register cancel. Saturation at either
  // end sets the matching sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        case ({w_inc[i], w_dec[i]})
          2'b10: begin
            if (r_cnt[i] == CNT_MAX) r_overflow <= 1'b1;
            else                     r_cnt[i] <= r_cnt[i] + CNT_ONE;
          end
          2'b01: begin
            if (r_cnt[i] == CNT_ZERO) r_underflow <= 1'b1;
            else                      r_cnt[i] <= r_cnt[i] - CNT_ONE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  writeback_stage_if #(.DATA_W(16), .NREG(8)) bus ();

  writeback_stage #(.DATA_W(16), .NREG(8), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, land 1ns after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic v, input logic [2:0] d, input logic m2r,
                     input logic [15:0] alu, input logic [15:0] rd);
    bus.mem_valid      = v;
    bus.mem_RegWrite   = v;
    bus.mem_MemtoReg   = m2r;
    bus.mem_dest_reg   = d;
    bus.mem_alu_result = alu;
    bus.mem_read_data  = rd;
  endtask

  task automatic issue(input logic v, input logic [2:0] d);
    bus.issue_valid    = v;
    bus.issue_RegWrite = v;
    bus.issue_dest_reg = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    mem(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    issue(1'b0, 3'd0);
    bus.rs1_addr = 3'd0; bus.rs2_addr = 3'd0;
    bus.rs1_use  = 1'b0; bus.rs2_use  = 1'b0;

    // reset state
    cyc(); cyc();
    chk("rst_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("rst_wreg",     32'(bus.write_register), 32'd0);
    chk("rst_wdata",    32'(bus.write_Data), 32'd0);
    chk("rst_stall",    32'(bus.hazard_stall), 32'd0);
    chk("rst_flags",    32'({bus.sb_overflow, bus.sb_underflow}), 32'd0);
    rst_n = 1'b1;

    // ALU result path, 1-cycle latency (issue alongside so the retire is legal)
    mem(1'b1, 3'd3, 1'b0, 16'h1234, 16'hDEAD);
    issue(1'b1, 3'd3);
    cyc();
    mem(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    issue(1'b0, 3'd0);
    #1;
    chk("alu_regwrite", 32'(bus.RegWrite), 32'd1);
    chk("alu_wreg",     32'(bus.write_register), 32'd3);
    chk("alu_wdata",    32'(bus.write_Data), 32'h1234);
    cyc();
    chk("idle_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("idle_hold_reg", 32'(bus.write_register), 32'd3);
    chk("idle_hold_dat", 32'(bus.write_Data), 32'h1234);

    // load data path
    mem(1'b1, 3'd5, 1'b1, 16'h0001, 16'hBEEF);
    issue(1'b1, 3'd5);
    cyc();
    mem(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    issue(1'b0, 3'd0);
    #1;
    chk("ld_wreg",  32'(bus.write_register), 32'd5);
    chk("ld_wdata", 32'(bus.write_Data), 32'hBEEF);
    cyc();
    chk("ld_no_underflow", 32'(bus.sb_underflow), 32'd0);

    // RAW stall, then bypass when the write appears on the port
    issue(1'b1, 3'd2);
    cyc();
    issue(1'b0, 3'd0);
    bus.rs1_addr = 3'd2; bus.rs1_use = 1'b1;
    #1;
    chk("raw_stall", 32'(bus.hazard_stall), 32'd1);
    chk("raw_nobyp", 32'(bus.bypass_1_en), 32'd0);
    mem(1'b1, 3'd2, 1'b0, 16'h0A0A, 16'h0);
    cyc();
    mem(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("byp_stall", 32'(bus.hazard_stall), 32'd0);
    chk("byp_en",    32'(bus.bypass_1_en), 32'd1);
    cyc();
    chk("post_stall", 32'(bus.hazard_stall), 32'd0);
    chk("post_byp",   32'(bus.bypass_1_en), 32'd0);
    bus.rs1_use = 1'b0;

    // counter depth on reg 4
    issue(1'b1, 3'd4);
    #1;
    chk("d_iss1_stall", 32'(bus.hazard_stall), 32'd0);
    cyc(); cyc(); cyc();
    chk("full_stall", 32'(bus.hazard_stall), 32'd1);
    cyc();
    chk("full_hold_stall", 32'(bus.hazard_stall), 32'd1);
    chk("full_no_ovf",     32'(bus.sb_overflow), 32'd0);
    mem(1'b1, 3'd4, 1'b0, 16'h4444, 16'h0);
    cyc();
    mem(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("full_retire_nostall", 32'(bus.hazard_stall), 32'd0);
    cyc();
    chk("full_still3", 32'(bus.hazard_stall), 32'd1);
    issue(1'b0, 3'd0);
    mem(1'b1, 3'd4, 1'b0, 16'h4444, 16'h0);
    cyc(); cyc(); cyc();
    mem(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    cyc();
    bus.rs1_addr = 3'd4; bus.rs1_use = 1'b1;
    #1;
    chk("drain4_nostall", 32'(bus.hazard_stall), 32'd0);
    chk("drain4_flags", 32'({bus.sb_overflow, bus.sb_underflow}), 32'd0);
    bus.rs1_use = 1'b0;

    // simultaneous issue + retire on reg 6
    issue(1'b1, 3'd6);
    cyc();
    issue(1'b0, 3'd0);
    mem(1'b1, 3'd6, 1'b0, 16'h6666, 16'h0);
    cyc();
    mem(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    issue(1'b1, 3'd6);
    #1;
    chk("sim_nostall", 32'(bus.hazard_stall), 32'd0);
    cyc();
    issue(1'b0, 3'd0);
    bus.rs2_addr = 3'd6; bus.rs2_use = 1'b1;
    #1;
    chk("sim_cnt1_stall", 32'(bus.hazard_stall), 32'd1);
    bus.rs2_use = 1'b0;
    #1;
    chk("sim_nouse_stall", 32'(bus.hazard_stall), 32'd0);
    chk("sim_nouse_byp",   32'(bus.bypass_2_en), 32'd0);
    mem(1'b1, 3'd6, 1'b0, 16'h6667, 16'h0);
    cyc();
    mem(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    cyc();
    bus.rs2_use = 1'b1;
    #1;
    chk("sim_drained", 32'(bus.hazard_stall), 32'd0);
    bus.rs2_use = 1'b0;

    // underflow on reg 7 (never issued), sticky
    mem(1'b1, 3'd7, 1'b0, 16'h7777, 16'h0);
    cyc();
    mem(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("uf_before", 32'(bus.sb_underflow), 32'd0);
    cyc();
    chk("uf_set", 32'(bus.sb_underflow), 32'd1);
    cyc();
    chk("uf_sticky", 32'(bus.sb_underflow), 32'd1);

    // asynchronous reset while a write is on the port
    mem(1'b1, 3'd1, 1'b0, 16'h1111, 16'h0);
    cyc();
    mem(1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("pre_arst_regwrite", 32'(bus.RegWrite), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_regwrite", 32'(bus.RegWrite), 32'd0);
    chk("arst_uf",       32'(bus.sb_underflow), 32'd0);
    chk("arst_wdata",    32'(bus.write_Data), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
